d_mem_lsu: RTL and testbench

Core-side load/store initiator for the data-cache port. Accepts one load or store per request from the execute stage, drives the cache's `data_enable`/`data_read`/`mem_wstrb`/`ram_address`/`ram_store` handshake, and samples `ram_fetch` and `d_cache_miss`. It returns sign- or zero-extended load data, or a fault code, to the core as a single-cycle response pulse. It sits between the core pipeline and the data cache, replacing the ad-hoc strobe logic in the core.

---
 rtl/d_mem_lsu.sv | 161 ++++++++++++++++
 tb/tb_d_mem_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_mem_lsu.sv
// d_mem_lsu: core-side load/store initiator for the data-cache port.
// One request in flight; fault codes or extended load data returned as a pulse.
module d_mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_fault,
    output logic        data_enable,
    output logic        data_read,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] ram_address,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_fetch,
    input  logic        d_cache_miss
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        LOAD_WAIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        st_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  chk_fault;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign off       = addr_q[1:0];

    // Classify the incoming request; illegal funct3 outranks misalignment
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_store) begin
            illegal = (req_funct3 > 3'd2);
        end else begin
            illegal = (req_funct3[1:0] == 2'b11) ||
                      (req_funct3[2] && req_funct3[1]);
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (illegal) begin
            chk_fault = 2'b11;
        end else if (misaligned) begin
            chk_fault = 2'b01;
        end else begin
            chk_fault = 2'b00;
        end
    end

    // Byte-lane strobe for the captured store and lane pick for loads
    always_comb begin
        case (f3_q[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        lane_byte = ram_fetch[{off, 3'b000} +: 8];
        lane_half = off[1] ? ram_fetch[31:16] : ram_fetch[15:0];
        case (f3_q[1:0])
            2'b00:   load_data = {{24{~f3_q[2] & lane_byte[7]}}, lane_byte};
            2'b01:   load_data = {{16{~f3_q[2] & lane_half[15]}}, lane_half};
            default: load_data = ram_fetch;
        endcase
    end

    // Next state and cache-port drive; the port is quiet outside REQ
    always_comb begin
        state_next  = state;
        data_enable = 1'b0;
        data_read   = 1'b0;
        mem_wstrb   = 4'b0000;
        ram_address = 32'd0;
        ram_store   = 32'd0;
        unique case (state)
            IDLE: begin
                if (accept && (chk_fault == 2'b00)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                data_enable = 1'b1;
                data_read   = ~st_q;
                mem_wstrb   = st_q ? strb : 4'b0000;
                ram_address = addr_q;
                ram_store   = wdata_q;
                if (!st_q && !d_cache_miss) begin
                    state_next = LOAD_WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD_WAIT: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State, request capture and the registered response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            st_q       <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_fault <= 2'b00;
        end else begin
            state      <= state_next;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_fault <= 2'b00;
            if (accept) begin
                st_q    <= req_store;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (chk_fault != 2'b00) begin
                    resp_valid <= 1'b1;
                    resp_fault <= chk_fault;
                end
            end
            if ((state == REQ) && (st_q || d_cache_miss)) begin
                resp_valid <= 1'b1;
                resp_fault <= d_cache_miss ? 2'b10 : 2'b00;
            end
            if (state == LOAD_WAIT) begin
                resp_valid <= 1'b1;
                resp_data  <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_d_mem_lsu.sv
// tb_d_mem_lsu: randomized scoreboard bench for d_mem_lsu.
// A byte-array reference model predicts responses and cache-port activity.
module tb_d_mem_lsu;

    localparam int MEMB = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_fault;
    logic        data_enable;
    logic        data_read;
    logic [3:0]  mem_wstrb;
    logic [31:0] ram_address;
    logic [31:0] ram_store;
    logic [31:0] ram_fetch;
    logic        d_cache_miss;

    int cyc       = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    bit mon_en    = 1'b0;
    int busy_from = 1;
    int busy_to   = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic [1:0]  fault;
    } rexp_t;

    typedef struct {
        int          due;
        logic        rd;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cexp_t;

    rexp_t rq[$];
    cexp_t cq[$];

    logic [7:0]  rmem [MEMB];
    logic [31:0] cmem [MEMB/4];

    d_mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_fault   (resp_fault),
        .data_enable  (data_enable),
        .data_read    (data_read),
        .mem_wstrb    (mem_wstrb),
        .ram_address  (ram_address),
        .ram_store    (ram_store),
        .ram_fetch    (ram_fetch),
        .d_cache_miss (d_cache_miss)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Base/bound check of the emulated cache: anything past MEMB misses
    assign d_cache_miss = data_enable && (ram_address >= 32'(MEMB));

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Emulated cache: registered read data, strobed write of low-aligned data
    always @(posedge clk) begin
        int j;
        j = 0;
        if (data_enable && !d_cache_miss) begin
            if (data_read) begin
                ram_fetch <= cmem[ram_address[8:2]];
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_wstrb[i]) begin
                        cmem[ram_address[8:2]][8*i +: 8] <= ram_store[8*j +: 8];
                        j++;
                    end
                end
                ram_fetch <= $urandom;
            end
        end else begin
            ram_fetch <= $urandom;
        end
    end

    // Reference model: request accepted in cycle n
    task automatic model(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int n);
        int          size;
        int          lat;
        logic [31:0] v;
        rexp_t       r;
        cexp_t       c;
        bit legal;
        legal = st ? (f3 <= 3'd2)
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size    = 1 << f3[1:0];
        r.data  = 32'd0;
        r.fault = 2'b00;
        if (!legal) begin
            r.fault = 2'b11;
            lat = 1;
        end else if ((a % 32'(size)) != 0) begin
            r.fault = 2'b01;
            lat = 1;
        end else begin
            c.due   = n + 1;
            c.rd    = !st;
            c.strb  = st ? 4'(((1 << size) - 1) << a[1:0]) : 4'b0000;
            c.addr  = a;
            c.wdata = wd;
            cq.push_back(c);
            lat = 2;
            if (a >= 32'(MEMB)) begin
                r.fault = 2'b10;
            end else if (st) begin
                for (int i = 0; i < size; i++)
                    rmem[9'(a) + 9'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++)
                    v[8*i +: 8] = rmem[9'(a) + 9'(i)];
                if (!f3[2] && size < 4 && v[8*size-1])
                    v = v | (32'hFFFF_FFFF << (8*size));
                r.data = v;
                lat = 3;
            end
        end
        r.due = n + lat;
        rq.push_back(r);
        busy_from = n + 1;
        busy_to   = n + lat - 1;
    endtask

    // Present a request at a falling edge and hold it until accepted
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bit done;
        done       = 1'b0;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        for (int k = 0; k < 8 && !done; k++) begin
            if (req_ready) begin
                model(st, f3, a, wd, cyc);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            fail("accept_timeout");
            req_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT presents activity
    always @(negedge clk) begin
        if (mon_en) begin
            rexp_t r;
            cexp_t c;
            chk("req_ready", 64'(req_ready),
                (cyc >= busy_from && cyc <= busy_to) ? 64'd0 : 64'd1);
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    fail("resp_unexpected");
                end else begin
                    r = rq.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(r.due));
                    chk("resp_data", 64'(resp_data), 64'(r.data));
                    chk("resp_fault", 64'(resp_fault), 64'(r.fault));
                end
            end else begin
                chk("resp_idle_zero", 64'({resp_fault, resp_data}), 64'd0);
                if (rq.size() != 0 && rq[0].due <= cyc) begin
                    fail("resp_missing");
                    void'(rq.pop_front());
                end
            end
            if (data_enable) begin
                if (cq.size() == 0) begin
                    fail("cache_unexpected");
                end else begin
                    c = cq.pop_front();
                    chk("cache_cycle", 64'(cyc), 64'(c.due));
                    chk("data_read", 64'(data_read), 64'(c.rd));
                    chk("mem_wstrb", 64'(mem_wstrb), 64'(c.strb));
                    chk("ram_address", 64'(ram_address), 64'(c.addr));
                    chk("ram_store", 64'(ram_store), 64'(c.wdata));
                end
            end else begin
                chk("cache_idle_zero",
                    64'({data_read, mem_wstrb, ram_address, ram_store}),
                    64'd0);
                if (cq.size() != 0 && cq[0].due <= cyc) begin
                    fail("cache_missing");
                    void'(cq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        st;
        for (int i = 0; i < MEMB/4; i++) begin
            w = (i == 64) ? 32'h1180_3344 : $urandom;
            cmem[i] = w;
            for (int b = 0; b < 4; b++) rmem[4*i+b] = w[8*b +: 8];
        end
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 3'b000, 32'h0000_0102, $urandom);
        idle(3);
        issue(1'b0, 3'b100, 32'h0000_0102, $urandom);
        idle(3);
        issue(1'b1, 3'b001, 32'h0000_0012, 32'hDEAD_BEEF);
        idle(2);
        issue(1'b0, 3'b010, 32'h0000_0006, $urandom);
        idle(1);
        issue(1'b0, 3'b011, 32'h0000_0040, $urandom);
        idle(1);
        issue(1'b0, 3'b010, 32'h0000_0204, $urandom);
        idle(2);
        issue(1'b0, 3'b001, 32'h0000_0012, $urandom);
        idle(3);
        issue(1'b1, 3'b010, 32'h0000_0020, $urandom);
        issue(1'b0, 3'b001, 32'h0000_0022, $urandom);
        idle(4);

        issue(1'b0, 3'b010, 32'h0000_0040, $urandom);
        idle(1);
        rst = 1'b1;
        rq.delete();
        cq.delete();
        busy_to = cyc;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle(1);

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                f3 = 3'($urandom);
            end else if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            a = 32'($urandom_range(0, MEMB + 63));
            if ($urandom_range(0, 9) < 7)
                a = a & ~32'((1 << f3[1:0]) - 1);
            issue(st, f3, a, $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(10);
        chk("drain", 64'(rq.size() + cq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
